// File: rtl/mem_byte_master.sv
// -----------------------------------------------------------------------------
// mem_byte_master
//
// Initiator-side access engine sitting between the multicycle CPU datapath and
// the 8-bit, byte-addressed unified memory. A single load/store of 1, 2 or 4
// bytes is split into byte transactions. The most-significant byte sits at the
// lowest address (big-endian). Load data is reassembled and then sign- or
// zero-extended.
//
// Ports
//   i_clk, i_rst      rising-edge clock, synchronous active-high reset
//   i_req             request strobe, only looked at while idle
//   i_we              1 = store, 0 = load
//   i_size            00 byte, 01 half, 10 word, 11 illegal
//   i_signed          loads: 1 = sign-extend, 0 = zero-extend
//   i_addr, i_wdata   byte address and right-justified store data
//   o_busy            high in ACCESS and FINISH
//   o_done, o_err     one-cycle completion pulse / error pulse (with o_done)
//   o_rdata           last successful load result, held between loads
//   o_mem_*           byte-wide memory port; i_mem_rdata is combinational
// -----------------------------------------------------------------------------
module mem_byte_master #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state;
    logic              we_q;
    logic              signed_q;
    logic [2:0]        n_q;
    logic [1:0]        k_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       acc_q;

    // Pick byte idx (0 = bits [7:0]) out of a 32-bit word.
    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    // Extend the low n bytes of v to 32 bits, signed or unsigned.
    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] n,
                                           input logic sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = v[7:0];
        h = v[15:0];
        case (n)
            3'd1:    extend = sgn ? 32'(b) : {24'h0, v[7:0]};
            3'd2:    extend = sgn ? 32'(h) : {16'h0, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    // Request decode, evaluated against the live inputs while idle.
    logic [2:0] req_n;
    logic       req_range_err;
    logic       req_err;

    always_comb begin
        req_n = 3'd1;
        case (i_size)
            2'b00:   req_n = 3'd1;
            2'b01:   req_n = 3'd2;
            2'b10:   req_n = 3'd4;
            default: req_n = 3'd1;
        endcase
    end

    // The last byte must still fall inside the memory. Using 33 bits keeps a
    // request near 2^32 from wrapping back into range.
    assign req_range_err = ({1'b0, i_addr} + 33'(req_n) - 33'd1) >= (33'd1 << ADDR_W);

    assign req_err = (i_size == 2'b11)
                   | ((i_size == 2'b01) & i_addr[0])
                   | ((i_size == 2'b10) & (i_addr[1:0] != 2'b00))
                   | req_range_err;

    // ACCESS bookkeeping.
    logic        last_byte;
    logic [1:0]  idx_next;
    logic [31:0] acc_next;

    assign last_byte = ({1'b0, k_q} == (n_q - 3'd1));
    // Byte lane for beat k+1 is N-1-(k+1), counted from the LSB.
    assign idx_next  = 2'(n_q - 3'd2 - {1'b0, k_q});
    // Bytes arrive MSB first, so they shift in from the bottom.
    assign acc_next  = {acc_q[23:0], i_mem_rdata};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            n_q         <= 3'd0;
            k_q         <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            acc_q       <= 32'h0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_rdata     <= 32'h0;
            o_mem_addr  <= '0;
            o_mem_re    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    o_err  <= 1'b0;
                    if (i_req) begin
                        we_q     <= i_we;
                        signed_q <= i_signed;
                        n_q      <= req_n;
                        addr_q   <= i_addr[ADDR_W-1:0];
                        wdata_q  <= i_wdata;
                        k_q      <= 2'd0;
                        acc_q    <= 32'h0;
                        o_busy   <= 1'b1;
                        if (req_err) begin
                            // Rejected requests never touch memory.
                            state  <= FINISH;
                            o_done <= 1'b1;
                            o_err  <= 1'b1;
                        end else begin
                            state       <= ACCESS;
                            o_mem_addr  <= i_addr[ADDR_W-1:0];
                            o_mem_we    <= i_we;
                            o_mem_re    <= ~i_we;
                            o_mem_wdata <= i_we ? sel_byte(i_wdata, 2'(req_n - 3'd1)) : 8'h00;
                        end
                    end
                end

                ACCESS: begin
                    if (!we_q) begin
                        acc_q <= acc_next;
                    end
                    if (last_byte) begin
                        state       <= FINISH;
                        o_mem_addr  <= '0;
                        o_mem_re    <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_wdata <= 8'h00;
                        o_done      <= 1'b1;
                        o_err       <= 1'b0;
                        if (!we_q) begin
                            o_rdata <= extend(acc_next, n_q, signed_q);
                        end
                    end else begin
                        k_q         <= k_q + 2'd1;
                        o_mem_addr  <= addr_q + ADDR_W'(k_q) + ADDR_W'(1);
                        o_mem_wdata <= we_q ? sel_byte(wdata_q, idx_next) : 8'h00;
                    end
                end

                FINISH: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                    o_err  <= 1'b0;
                    o_busy <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_master.sv
// -----------------------------------------------------------------------------
// tb_mem_byte_master
//
// Directed bench for mem_byte_master with a scoreboard. The driver pushes the
// expected completion for each request. A negedge monitor pops that entry on
// o_done and checks o_err, o_rdata, the strobe count, the busy-cycle count and
// each strobe address. A 256-byte memory model sits on the byte port.
// -----------------------------------------------------------------------------
module tb_mem_byte_master;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [1:0]  i_size = 2'b00;
    logic        i_signed = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_wdata = 32'h0;
    logic        o_busy, o_done, o_err;
    logic [31:0] o_rdata;
    logic [7:0]  o_mem_addr;
    logic        o_mem_re, o_mem_we;
    logic [7:0]  o_mem_wdata;
    logic [7:0]  i_mem_rdata;

    always #5 i_clk = ~i_clk;

    mem_byte_master #(.ADDR_W(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_size      (i_size),
        .i_signed    (i_signed),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_rdata     (o_rdata),
        .o_mem_addr  (o_mem_addr),
        .o_mem_re    (o_mem_re),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    logic [7:0] mem [0:255];
    assign i_mem_rdata = mem[o_mem_addr];
    always @(posedge i_clk) if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          nstb;
        int          nbusy;
        logic [7:0]  base;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          stb_cnt = 0;
    int          busy_cnt = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on o_done.
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst) begin
            sb.delete();
            stb_cnt  = 0;
            busy_cnt = 0;
        end else begin
            check("strobe_excl", {31'b0, o_mem_re & o_mem_we}, 32'h0);
            check("err_wo_done", {31'b0, o_err & ~o_done}, 32'h0);
            if (!o_mem_we) check("wdata_idle", {24'h0, o_mem_wdata}, 32'h0);
            if (o_mem_re | o_mem_we) begin
                if (sb.size() == 0) check("unexp_strobe", 32'h1, 32'h0);
                else check("mem_addr", {24'h0, o_mem_addr}, {24'h0, 8'(sb[0].base + 8'(stb_cnt))});
                stb_cnt++;
            end
            if (o_done) begin
                if (sb.size() == 0) begin
                    check("unexp_done", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("err", {31'b0, o_err}, {31'b0, e.err});
                    check("rdata", o_rdata, e.rdata);
                    check("strobes", 32'(stb_cnt), 32'(e.nstb));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.nbusy));
                    check("busy_at_done", {31'b0, o_busy}, 32'h1);
                end
                done_cnt++;
                stb_cnt  = 0;
                busy_cnt = 0;
            end else if (o_busy) begin
                busy_cnt++;
            end
        end
    end

    function automatic exp_t mk(input logic err, input logic [31:0] rd, input int n,
                                input logic [31:0] addr);
        exp_t e;
        e.err   = err;
        e.rdata = rd;
        e.nstb  = err ? 0 : n;
        e.nbusy = err ? 0 : n;
        e.base  = addr[7:0];
        return e;
    endfunction

    task automatic wait_done(input int target, input string name);
        for (int c = 0; c < 30 && done_cnt < target; c++) @(negedge i_clk);
        if (done_cnt < target) check({name, "_timeout"}, 32'(done_cnt), 32'(target));
    endtask

    // Issue one request. exp_rd is what o_rdata must be at completion.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic err, input logic [31:0] exp_rd, input int n);
        int d0;
        d0 = done_cnt;
        sb.push_back(mk(err, exp_rd, n, addr));
        last_rd = exp_rd;
        @(posedge i_clk); #1;
        i_req = 1'b1; i_we = we; i_size = size; i_signed = sgn;
        i_addr = addr; i_wdata = wdata;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        wait_done(d0 + 1, "issue");
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset, then idle.
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("rst_busy", {31'b0, o_busy}, 32'h0);
            check("rst_done", {31'b0, o_done}, 32'h0);
            check("rst_strobes", {30'b0, o_mem_re, o_mem_we}, 32'h0);
            check("rst_rdata", o_rdata, 32'h0);
            check("rst_addr", {24'h0, o_mem_addr}, 32'h0);
        end

        // Word store, then word load back.
        issue(1'b1, 2'b10, 1'b0, 32'h80, 32'hDEADBEEF, 1'b0, last_rd, 4);
        check("mem80", {24'h0, mem[8'h80]}, 32'hDE);
        check("mem81", {24'h0, mem[8'h81]}, 32'hAD);
        check("mem82", {24'h0, mem[8'h82]}, 32'hBE);
        check("mem83", {24'h0, mem[8'h83]}, 32'hEF);
        issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b0, 32'hDEADBEEF, 4);

        // Sub-word loads.
        issue(1'b0, 2'b00, 1'b1, 32'h83, 32'h0, 1'b0, 32'hFFFFFFEF, 1);
        issue(1'b0, 2'b00, 1'b0, 32'h83, 32'h0, 1'b0, 32'h000000EF, 1);
        issue(1'b0, 2'b01, 1'b1, 32'h82, 32'h0, 1'b0, 32'hFFFFBEEF, 2);
        issue(1'b0, 2'b01, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0000DEAD, 2);

        // Errors: o_rdata must stay at 0x0000DEAD, no strobes.
        issue(1'b0, 2'b10, 1'b0, 32'h81, 32'h0, 1'b1, last_rd, 4);
        issue(1'b1, 2'b01, 1'b0, 32'h85, 32'h1234, 1'b1, last_rd, 2);
        issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b1, last_rd, 1);
        issue(1'b0, 2'b10, 1'b0, 32'hFE, 32'h0, 1'b1, last_rd, 4);
        issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b1, last_rd, 1);
        issue(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b1, last_rd, 4);

        // Top-of-memory boundary accesses are legal.
        issue(1'b1, 2'b00, 1'b0, 32'hFF, 32'h000000A5, 1'b0, last_rd, 1);
        check("memFF", {24'h0, mem[8'hFF]}, 32'hA5);
        issue(1'b0, 2'b00, 1'b1, 32'hFF, 32'h0, 1'b0, 32'hFFFFFFA5, 1);
        issue(1'b0, 2'b01, 1'b0, 32'hFE, 32'h0, 1'b0, 32'h000000A5, 2);

        // Busy rejection: hold i_req through a word load while switching the
        // inputs to a byte load; that one is taken on the first idle cycle.
        d0 = done_cnt;
        sb.push_back(mk(1'b0, 32'hDEADBEEF, 4, 32'h80));
        sb.push_back(mk(1'b0, 32'h000000AD, 1, 32'h81));
        last_rd = 32'h000000AD;
        @(posedge i_clk); #1;
        i_req = 1'b1; i_we = 1'b0; i_size = 2'b10; i_signed = 1'b0; i_addr = 32'h80;
        @(posedge i_clk); #1;
        i_size = 2'b00; i_addr = 32'h81;
        @(negedge i_clk);
        for (int c = 0; c < 30 && o_busy; c++) @(negedge i_clk);
        check("busy_drop", {31'b0, o_busy}, 32'h0);
        check("one_done", 32'(done_cnt), 32'(d0 + 1));
        @(posedge i_clk); #1;
        i_req = 1'b0;
        wait_done(d0 + 2, "busy_rej");

        // Reset in the middle of a word store to 0x90: only the first byte lands.
        d0 = done_cnt;
        sb.push_back(mk(1'b0, last_rd, 4, 32'h90));
        @(posedge i_clk); #1;
        i_req = 1'b1; i_we = 1'b1; i_size = 2'b10; i_addr = 32'h90; i_wdata = 32'h11223344;
        @(posedge i_clk); #1;
        i_req = 1'b0; i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("mrst_strobes", {30'b0, o_mem_re, o_mem_we}, 32'h0);
        check("mrst_busy", {31'b0, o_busy}, 32'h0);
        check("mrst_rdata", o_rdata, 32'h0);
        check("mrst_wdata", {24'h0, o_mem_wdata}, 32'h0);
        repeat (6) @(negedge i_clk);
        check("mrst_no_done", 32'(done_cnt), 32'(d0));
        check("mem90", {24'h0, mem[8'h90]}, 32'h11);
        check("mem91", {24'h0, mem[8'h91]}, 32'h00);
        check("mem93", {24'h0, mem[8'h93]}, 32'h00);
        last_rd = 32'h0;
        issue(1'b0, 2'b10, 1'b0, 32'h90, 32'h0, 1'b0, 32'h11000000, 4);

        repeat (3) @(negedge i_clk);
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
